// File: rtl/imsic_pkg.sv
// Shared types and constants for the IMSIC setipnum write path.
// A request names one interrupt file (IMSIC index, file index) and the identity to set pending.
package imsic_pkg;

    localparam int unsigned MAX_IMSICS = 4;
    localparam int unsigned MAX_FILES  = 8;
    localparam int unsigned FILE_M     = 0;
    localparam int unsigned FILE_S     = 1;
    localparam int unsigned EIID_W     = 32;

    typedef struct packed {
        logic [1:0]        imsic;
        logic [2:0]        file;
        logic [EIID_W-1:0] eiid;
    } setipnum_req_t;

    localparam int unsigned REQ_W = $bits(setipnum_req_t);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/imsic_setipnum_fifo.sv
// Synchronous FIFO of setipnum requests with wrap-bit pointers.
// Push while full and pop while empty are ignored.
module imsic_setipnum_fifo
    import imsic_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [REQ_W-1:0]         i_data,
    input  logic                     i_pop,
    output logic [REQ_W-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    setipnum_req_t mem_q [DEPTH];
    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic          do_push;
    logic          do_pop;

    assign o_count = wr_ptr_q - rd_ptr_q;
    assign o_full  = (o_count == CW'(DEPTH));
    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_data  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is never reset; the pointers alone define which entries are live.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/imsic_setipnum_arbiter.sv
// Round-robin arbiter that funnels MSI requesters into the IMSIC setipnum write ports.
// One request admitted per cycle into a FIFO; one registered write strobe emitted per cycle.
module imsic_setipnum_arbiter
    import imsic_pkg::*;
#(
    parameter int NR_REQ                = 3,
    parameter int NR_SRC_LEN            = 32,
    parameter int NR_SRC                = 64,
    parameter int NR_IMSICS             = 1,
    parameter int NR_VS_FILES_PER_IMSIC = 0,
    parameter int FIFO_DEPTH            = 4,
    localparam int NR_INTP_FILES        = 2 + NR_VS_FILES_PER_IMSIC
) (
    input  logic                                                    i_clk,
    input  logic                                                    i_rst,
    input  logic                                                    i_enable,
    input  logic [NR_REQ-1:0]                                       i_req_valid,
    output logic [NR_REQ-1:0]                                       o_req_ready,
    input  logic [NR_REQ-1:0][1:0]                                  i_req_imsic,
    input  logic [NR_REQ-1:0][2:0]                                  i_req_file,
    input  logic [NR_REQ-1:0][NR_SRC_LEN-1:0]                       i_req_eiid,
    output logic [NR_IMSICS-1:0][NR_INTP_FILES-1:0][NR_SRC_LEN-1:0] o_setipnum,
    output logic [NR_IMSICS-1:0][NR_INTP_FILES-1:0]                 o_setipnum_we,
    output logic                                                    o_busy,
    output logic [15:0]                                             o_drop_cnt
);

    localparam int PW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [PW-1:0]       rr_q, rr_d;
    logic [15:0]         drop_q, drop_d;
    logic                can_accept;
    logic                gnt_vld;
    logic [NR_REQ-1:0]   gnt_oh;
    logic [1:0]          sel_imsic;
    logic [2:0]          sel_file;
    logic [NR_SRC_LEN-1:0] sel_eiid;
    logic                sel_ok;
    logic                push;
    logic                pop;
    setipnum_req_t       push_req;
    setipnum_req_t       head_req;
    logic [REQ_W-1:0]    head_raw;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;

    logic [NR_IMSICS-1:0][NR_INTP_FILES-1:0][NR_SRC_LEN-1:0] data_q, data_d;
    logic [NR_IMSICS-1:0][NR_INTP_FILES-1:0]                 we_q, we_d;

    // Arbitration: registered count only, so a full FIFO refuses even while it drains.
    assign can_accept = !i_rst && (fifo_count < CW'(FIFO_DEPTH));

    always_comb begin
        gnt_vld   = 1'b0;
        gnt_oh    = '0;
        rr_d      = rr_q;
        sel_imsic = '0;
        sel_file  = '0;
        sel_eiid  = '0;
        for (int k = 0; k < NR_REQ; k++) begin
            for (int r = 0; r < NR_REQ; r++) begin
                if (can_accept && !gnt_vld && i_req_valid[r] &&
                    (((int'(rr_q) + k) % NR_REQ) == r)) begin
                    gnt_vld   = 1'b1;
                    gnt_oh[r] = 1'b1;
                    rr_d      = PW'((r + 1) % NR_REQ);
                    sel_imsic = i_req_imsic[r];
                    sel_file  = i_req_file[r];
                    sel_eiid  = i_req_eiid[r];
                end
            end
        end
    end

    assign o_req_ready = gnt_oh;

    // Out-of-range targets are acknowledged so the requester is never stuck, but only counted.
    assign sel_ok = (sel_eiid != '0) &&
                    (sel_eiid < NR_SRC_LEN'(NR_SRC)) &&
                    (32'(sel_imsic) < 32'(NR_IMSICS)) &&
                    (32'(sel_file) < 32'(NR_INTP_FILES));

    assign push = gnt_vld && sel_ok && !fifo_full;
    assign pop  = i_enable && !fifo_empty;

    always_comb begin
        push_req.imsic = sel_imsic;
        push_req.file  = sel_file;
        push_req.eiid  = EIID_W'(sel_eiid);
        drop_d         = (gnt_vld && !sel_ok) ? sat_inc16(drop_q) : drop_q;
    end

    imsic_setipnum_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_data  (push_req),
        .i_pop   (pop),
        .o_data  (head_raw),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    assign head_req = head_raw;

    // Drain stage: decode the popped head into a one-hot strobe plus data for that file only.
    always_comb begin
        we_d   = '0;
        data_d = '0;
        for (int i = 0; i < NR_IMSICS; i++) begin
            for (int f = 0; f < NR_INTP_FILES; f++) begin
                if (pop && (head_req.imsic == 2'(i)) && (head_req.file == 3'(f))) begin
                    we_d[i][f]   = 1'b1;
                    data_d[i][f] = NR_SRC_LEN'(head_req.eiid);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_q   <= '0;
            drop_q <= '0;
            we_q   <= '0;
            data_q <= '0;
        end else begin
            rr_q   <= rr_d;
            drop_q <= drop_d;
            we_q   <= we_d;
            data_q <= data_d;
        end
    end

    assign o_setipnum    = data_q;
    assign o_setipnum_we = we_q;
    assign o_busy        = (fifo_count != '0);
    assign o_drop_cnt    = drop_q;

endmodule

// File: tb/tb_imsic_setipnum_arbiter.sv
// Bench for imsic_setipnum_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations on grant order and strobe contents.
module tb_imsic_setipnum_arbiter;

    localparam int NR_REQ        = 3;
    localparam int NR_SRC_LEN    = 32;
    localparam int NR_SRC        = 64;
    localparam int NR_IMSICS     = 1;
    localparam int NR_VS         = 0;
    localparam int NR_INTP_FILES = 2 + NR_VS;
    localparam int FIFO_DEPTH    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    logic [NR_REQ-1:0]                                       valid = '0;
    logic [NR_REQ-1:0]                                       ready;
    logic [NR_REQ-1:0][1:0]                                  imsic = '0;
    logic [NR_REQ-1:0][2:0]                                  file  = '0;
    logic [NR_REQ-1:0][NR_SRC_LEN-1:0]                       eiid  = '0;
    logic [NR_IMSICS-1:0][NR_INTP_FILES-1:0][NR_SRC_LEN-1:0] setip;
    logic [NR_IMSICS-1:0][NR_INTP_FILES-1:0]                 we;
    logic                                                    busy;
    logic [15:0]                                             drop;

    imsic_setipnum_arbiter #(
        .NR_REQ                (NR_REQ),
        .NR_SRC_LEN            (NR_SRC_LEN),
        .NR_SRC                (NR_SRC),
        .NR_IMSICS             (NR_IMSICS),
        .NR_VS_FILES_PER_IMSIC (NR_VS),
        .FIFO_DEPTH            (FIFO_DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_enable      (en),
        .i_req_valid   (valid),
        .o_req_ready   (ready),
        .i_req_imsic   (imsic),
        .i_req_file    (file),
        .i_req_eiid    (eiid),
        .o_setipnum    (setip),
        .o_setipnum_we (we),
        .o_busy        (busy),
        .o_drop_cnt    (drop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of targets, a round-robin index and a drop counter.
    typedef struct {
        int     im;
        int     fi;
        longint ei;
    } ent_t;

    ent_t   mq[$];
    int     mptr  = 0;
    int     mdrop = 0;
    int     mpush = 0;
    bit     ms_v  = 0;
    ent_t   ms;
    int     wait_cnt[NR_REQ];
    longint strobe_log[$];

    always @(negedge clk) begin
        int   g;
        bit   can;
        ent_t e;
        logic [NR_REQ-1:0]                                       exp_rdy;
        logic [NR_IMSICS-1:0][NR_INTP_FILES-1:0]                 exp_we;
        logic [NR_IMSICS-1:0][NR_INTP_FILES-1:0][NR_SRC_LEN-1:0] exp_data;

        g   = -1;
        can = !rst && (mq.size() < FIFO_DEPTH);
        if (can) begin
            for (int k = 0; k < NR_REQ; k++) begin
                if (g < 0 && valid[(mptr + k) % NR_REQ]) g = (mptr + k) % NR_REQ;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;

        exp_we   = '0;
        exp_data = '0;
        for (int i = 0; i < NR_IMSICS; i++) begin
            for (int f = 0; f < NR_INTP_FILES; f++) begin
                if (ms_v && ms.im == i && ms.fi == f) begin
                    exp_we[i][f]   = 1'b1;
                    exp_data[i][f] = ms.ei[NR_SRC_LEN-1:0];
                end
            end
        end

        chk("ready", 64'(ready), 64'(exp_rdy));
        chk("busy", 64'(busy), 64'(mq.size() != 0));
        chk("drop_cnt", 64'(drop), 64'(mdrop));
        chk("we", 64'(we), 64'(exp_we));
        chk("setipnum", 64'(setip), 64'(exp_data));

        for (int i = 0; i < NR_IMSICS; i++)
            for (int f = 0; f < NR_INTP_FILES; f++)
                if (we[i][f] === 1'b1) strobe_log.push_back(longint'(setip[i][f]));

        for (int r = 0; r < NR_REQ; r++) begin
            if (rst || !valid[r] || g == r) wait_cnt[r] = 0;
            else if (can) begin
                wait_cnt[r]++;
                chk("starvation", 64'(wait_cnt[r] >= NR_REQ), 64'(0));
            end
        end

        if (rst) begin
            mq.delete();
            mptr  = 0;
            mdrop = 0;
            ms_v  = 0;
        end else begin
            ms_v = 0;
            if (en && mq.size() > 0) begin
                ms   = mq.pop_front();
                ms_v = 1;
            end
            if (g >= 0) begin
                e.im = int'(imsic[g]);
                e.fi = int'(file[g]);
                e.ei = longint'(eiid[g]);
                if (e.ei != 0 && e.ei < NR_SRC && e.im < NR_IMSICS && e.fi < NR_INTP_FILES) begin
                    mq.push_back(e);
                    mpush++;
                end else if (mdrop < 65535) begin
                    mdrop++;
                end
                mptr = (g + 1) % NR_REQ;
            end
        end
    end

    // Per-requester pending payloads, presented in order and held until granted.
    logic [36:0] pq [NR_REQ][32];
    int          ph [NR_REQ];
    int          pt [NR_REQ];
    int          gnt_log[$];

    task automatic enq(input int r, input int im, input int fi, input longint ei);
        pq[r][pt[r] % 32] = {2'(im), 3'(fi), ei[31:0]};
        pt[r]++;
    endtask

    task automatic present();
        for (int r = 0; r < NR_REQ; r++) begin
            valid[r] = (ph[r] != pt[r]);
            if (valid[r]) {imsic[r], file[r], eiid[r]} = pq[r][ph[r] % 32];
            else          {imsic[r], file[r], eiid[r]} = '0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic drive(input int max_cyc, input bit stress, output int ngr);
        logic [NR_REQ-1:0] g;
        ngr = 0;
        for (int c = 0; c < max_cyc; c++) begin
            if (stress) begin
                en = ($urandom_range(0, 3) != 0);
                for (int r = 0; r < NR_REQ; r++) begin
                    if (ph[r] == pt[r] && $urandom_range(0, 1) == 1) begin
                        case ($urandom_range(0, 15))
                            0:       enq(r, 0, 0, 0);
                            1:       enq(r, 0, 1, NR_SRC + $urandom_range(0, 100));
                            2:       enq(r, $urandom_range(1, 3), 0, 7);
                            3:       enq(r, 0, $urandom_range(2, 7), 9);
                            default: enq(r, 0, $urandom_range(0, 1), $urandom_range(1, NR_SRC - 1));
                        endcase
                    end
                end
            end
            present();
            if (!stress && valid == '0) break;
            @(negedge clk);
            g = ready & valid;
            cyc();
            for (int r = 0; r < NR_REQ; r++) begin
                if (g[r]) begin
                    ph[r]++;
                    ngr++;
                    gnt_log.push_back(r);
                end
            end
        end
        present();
    endtask

    function automatic longint strobe_at(input int i);
        if (i < 0 || i >= strobe_log.size()) return -1;
        return strobe_log[i];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int gbase;
        for (int r = 0; r < NR_REQ; r++) begin
            ph[r] = 0;
            pt[r] = 0;
            wait_cnt[r] = 0;
        end

        // Reset state
        idle(2);
        @(negedge clk);
        chk("rst_ready", 64'(ready), 64'(0));
        chk("rst_we", 64'(we), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_drop", 64'(drop), 64'(0));
        cyc();
        rst = 1'b0;
        idle(1);

        // Single request: strobe two cycles after accept
        base = strobe_log.size();
        enq(0, 0, 0, 5);
        drive(10, 0, n);
        chk("single_grants", 64'(n), 64'(1));
        @(negedge clk);
        chk("single_we_early", 64'(we), 64'(0));
        chk("single_busy", 64'(busy), 64'(1));
        cyc();
        @(negedge clk);
        chk("single_we", 64'(we), 64'(2'b01));
        chk("single_data", 64'(setip[0][0]), 64'(5));
        chk("single_busy_done", 64'(busy), 64'(0));
        cyc();

        // Three requesters from pointer 0
        do_reset();
        base  = strobe_log.size();
        gbase = gnt_log.size();
        enq(0, 0, 0, 1);
        enq(1, 0, 1, 2);
        enq(2, 0, 0, 3);
        drive(10, 0, n);
        chk("rr_grants", 64'(n), 64'(3));
        chk("rr_order0", 64'(gnt_log[gbase]), 64'(0));
        chk("rr_order1", 64'(gnt_log[gbase + 1]), 64'(1));
        chk("rr_order2", 64'(gnt_log[gbase + 2]), 64'(2));
        idle(5);
        chk("rr_strobe0", 64'(strobe_at(base)), 64'(1));
        chk("rr_strobe1", 64'(strobe_at(base + 1)), 64'(2));
        chk("rr_strobe2", 64'(strobe_at(base + 2)), 64'(3));
        gbase = gnt_log.size();
        enq(0, 0, 0, 4);
        enq(1, 0, 0, 5);
        enq(2, 0, 1, 6);
        drive(10, 0, n);
        chk("rr_again_first", 64'(gnt_log[gbase]), 64'(0));
        idle(5);

        // Drain disabled: FIFO fills to depth, then backpressure
        base = strobe_log.size();
        en   = 1'b0;
        for (int v = 10; v <= 15; v++) enq(0, 0, 0, v);
        drive(8, 0, n);
        chk("full_accepts", 64'(n), 64'(4));
        @(negedge clk);
        chk("full_ready_low", 64'(ready), 64'(0));
        cyc();
        en = 1'b1;
        drive(30, 0, n);
        chk("full_rest", 64'(n), 64'(2));
        idle(8);
        for (int v = 0; v < 6; v++) chk("full_order", 64'(strobe_at(base + v)), 64'(10 + v));

        // Invalid targets: acknowledged and counted, never strobed
        base = strobe_log.size();
        enq(0, 0, 0, 0);
        enq(1, 0, 0, 64);
        enq(2, 0, 3, 7);
        drive(10, 0, n);
        chk("drop_acks", 64'(n), 64'(3));
        idle(4);
        @(negedge clk);
        chk("drop_count", 64'(drop), 64'(3));
        chk("drop_no_strobe", 64'(strobe_log.size()), 64'(base));
        cyc();

        // Reset while half full discards buffered writes
        en = 1'b0;
        enq(0, 0, 0, 20);
        enq(0, 0, 1, 21);
        drive(6, 0, n);
        @(negedge clk);
        chk("half_busy", 64'(busy), 64'(1));
        cyc();
        rst = 1'b1;
        cyc();
        rst  = 1'b0;
        en   = 1'b1;
        base = strobe_log.size();
        idle(4);
        @(negedge clk);
        chk("postrst_no_strobe", 64'(strobe_log.size()), 64'(base));
        chk("postrst_busy", 64'(busy), 64'(0));
        chk("postrst_drop", 64'(drop), 64'(0));
        cyc();
        enq(1, 0, 1, 9);
        drive(10, 0, n);
        idle(4);
        chk("postrst_strobe", 64'(strobe_at(base)), 64'(9));
        chk("postrst_count", 64'(strobe_log.size()), 64'(base + 1));

        // Random stress against the model
        base = strobe_log.size();
        mpush = 0;
        drive(10000, 1, n);
        en = 1'b1;
        drive(200, 0, n);
        idle(12);
        chk("stress_all_strobed", 64'(strobe_log.size() - base), 64'(mpush));
        chk("stress_drained", 64'(busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imsic_setipnum_arbiter.md
Name: imsic_setipnum_arbiter

Overview:
Shares the per-IMSIC setipnum write ports between several MSI requesters, for example the AXI register map, the APLIC MSI generator and a debug injector. Each requester presents a target (IMSIC index, interrupt file index, EIID). A round-robin arbiter admits at most one request per cycle into a shallow FIFO. The FIFO drains one entry per cycle as a single-cycle setipnum write pulse to the addressed interrupt file. The block sits between the MSI sources and the IMSIC interrupt files.

Parameters:
NR_REQ, 3, number of requesters (1..8)
NR_SRC_LEN, 32, setipnum data width
NR_SRC, 64, number of implemented interrupt identities; valid EIIDs are 1..NR_SRC-1
NR_IMSICS, 1, number of IMSICs (1..4)
NR_VS_FILES_PER_IMSIC, 0, guest files per IMSIC
NR_INTP_FILES, 2+NR_VS_FILES_PER_IMSIC, files per IMSIC (derived; do not override)
FIFO_DEPTH, 4, buffered writes (power of two, >=2)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_enable  in  1  drain enable; 0 holds FIFO contents
i_req_valid  in  NR_REQ  request valid per requester
o_req_ready  out  NR_REQ  request accepted this cycle (grant)
i_req_imsic  in  NR_REQ x 2  target IMSIC index
i_req_file  in  NR_REQ x 3  target file (0=M, 1=S, 2..=VS)
i_req_eiid  in  NR_REQ x NR_SRC_LEN  interrupt identity
o_setipnum  out  NR_IMSICS x NR_INTP_FILES x NR_SRC_LEN  write data
o_setipnum_we  out  NR_IMSICS x NR_INTP_FILES  one-hot single-cycle write strobe
o_busy  out  1  FIFO non-empty
o_drop_cnt  out  16  saturating count of discarded requests

Behaviour:
- One clock and one reset: i_clk, with i_rst synchronous and active-high. Reset empties the FIFO, sets the RR pointer to 0, and drives o_setipnum, o_setipnum_we and o_drop_cnt to 0. o_req_ready and o_busy read 0 during and after reset until a request arrives.
- Arbitration is combinational from registered state.
  - can_accept = (count < FIFO_DEPTH), using the registered count. There is no same-cycle pop credit, so a full FIFO blocks even while popping.
  - When can_accept is high, grant the first i_req_valid bit at or after the RR pointer, modulo NR_REQ.
  - o_req_ready is one-hot at the granted bit, otherwise 0.
  - Transfer completes when valid & ready. Requesters hold their payload until ready.
  - On a transfer the pointer becomes grant+1 mod NR_REQ. With no transfer the pointer is unchanged.
- Validity check on the granted request:
  - The request is discarded if eiid==0, eiid>=NR_SRC, imsic>=NR_IMSICS or file>=NR_INTP_FILES.
  - A discarded request is still acknowledged (ready=1) but is not pushed.
  - o_drop_cnt increments by 1 per discard and saturates at 16'hFFFF.
- Pop: when i_enable=1 and count>0, pop the head.
  - Next cycle: o_setipnum_we[imsic][file]=1 and o_setipnum[imsic][file]=eiid. All other we bits are 0 and all other data fields are 0.
  - Outputs are registered. Minimum accept-to-strobe latency is 2 cycles: push at edge N, pop/register at edge N+1, strobe visible in cycle N+1 to N+2.
- Simultaneous push and pop when not full leaves count unchanged. Ordering is strict FIFO across all requesters.
- i_enable=0: no pop, and o_setipnum_we is 0 the next cycle. Pushes continue until the FIFO is full.
- Back-to-back writes to the same file produce consecutive strobes. There is no merging; the interrupt file tolerates repeated set-pending.
- o_busy = (count != 0), registered.
- Reset asserted mid-operation: all buffered writes are lost. No strobe is emitted in the cycle after reset.
- Pointers: wr_ptr and rd_ptr are log2(FIFO_DEPTH)+1 bits with wrap-around. count = wr_ptr - rd_ptr.

Decomposition:
- Package imsic_pkg:
  - typedef setipnum_req_t {imsic[1:0], file[2:0], eiid[NR_SRC_LEN-1:0]}
  - constants MAX_IMSICS=4, MAX_FILES=8, FILE_M=0, FILE_S=1.
- Sub-module imsic_setipnum_fifo: parametric synchronous FIFO of setipnum_req_t with push/pop, full/empty and count.
- The round-robin arbiter stays inline.

Test Plan:
- Reset, then single request: req0 {imsic0, file0, eiid 5} -> ready0 for 1 cycle; o_setipnum_we[0][0]=1 with data 5 exactly 2 cycles after accept; o_busy returns to 0.
- Three requesters valid together with eiids 1, 2, 3, pointer=0 -> grants in order 0, 1, 2 on consecutive cycles; strobes carry 1, 2, 3 in the same order. Re-asserting all three afterwards grants 0 first again.
- i_enable=0, requester 0 streams eiids 10..15 -> 4 accepted, then ready held low. Raise i_enable -> strobes 10, 11, 12, 13; then 14 and 15 are accepted and drained; order is preserved.
- Invalid requests (eiid 0, eiid 64, file 3 with NR_INTP_FILES=2) -> each acknowledged in 1 cycle; no strobe; o_drop_cnt = 3.
- FIFO half full, i_rst pulsed for 1 cycle -> no strobes afterwards; count 0; o_drop_cnt 0; next request is strobed normally.
- Stress: random valid patterns over 10k cycles with randomized i_enable -> scoreboard shows every accepted valid request strobed once, in order, with no grant starvation longer than NR_REQ arbitration cycles.
